// File: rtl/mips_alu_issue_pkg.sv
// Shared ALU opcodes, MIPS decode constants and the S1 control record for mips_alu_issue.
package mips_alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        BSRC_ZERO,
        BSRC_RT,
        BSRC_SEXT,
        BSRC_ZEXT
    } bsrc_e;

    // Operand values live beside this record so it stays independent of WIDTH.
    typedef struct packed {
        logic [2:0] op;
        logic       is_branch;
        logic       is_bne;
        logic       illegal;
        logic       bypass;
    } s1_ctrl_t;

endpackage

// File: rtl/mips_alu_issue_decode.sv
// Combinational MIPS opcode/funct decode into ALU op, operands and branch/illegal flags.
// Optional: MIPS_ALU_ISSUE_LUI_EN makes lui legal as an ALU-bypassed immediate load.
module mips_alu_decode
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm,
    output s1_ctrl_t         ctrl,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    bsrc_e bsrc;

    always_comb begin
        ctrl    = '0;
        ctrl.op = ALU_ADD;
        bsrc    = BSRC_ZERO;
        case (opcode)
            OP_RTYPE: begin
                bsrc = BSRC_RT;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.op = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.op = ALU_SUB;
                    FN_AND:          ctrl.op = ALU_AND;
                    FN_OR:           ctrl.op = ALU_OR;
                    FN_SLT:          ctrl.op = ALU_SLT;
                    default:         ctrl.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
                ctrl.op = ALU_ADD;
                bsrc    = BSRC_SEXT;
            end
            OP_SLTI: begin
                ctrl.op = ALU_SLT;
                bsrc    = BSRC_SEXT;
            end
            OP_ANDI: begin
                ctrl.op = ALU_AND;
                bsrc    = BSRC_ZEXT;
            end
            OP_ORI: begin
                ctrl.op = ALU_OR;
                bsrc    = BSRC_ZEXT;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.op        = ALU_SUB;
                bsrc           = BSRC_RT;
                ctrl.is_branch = 1'b1;
                ctrl.is_bne    = (opcode == OP_BNE);
            end
`ifdef MIPS_ALU_ISSUE_LUI_EN
            OP_LUI: begin
                ctrl.op     = ALU_OR;
                ctrl.bypass = 1'b1;
            end
`endif
            default: ctrl.illegal = 1'b1;
        endcase
        if (ctrl.illegal) begin
            bsrc = BSRC_ZERO;
        end
    end

    // Illegal and bypassed entries park the ALU on zero operands.
    always_comb begin
        a = (ctrl.illegal || ctrl.bypass) ? '0 : rs_val;
        case (bsrc)
            BSRC_RT:   b = rt_val;
            BSRC_SEXT: b = {{(WIDTH-16){imm[15]}}, imm};
            BSRC_ZEXT: b = {{(WIDTH-16){1'b0}}, imm};
            default:   b = '0;
        endcase
    end

endmodule

// File: rtl/mips_alu_issue.sv
// Two-stage execute issue for the shared ALU: S1 drives the ALU, S2 holds the result and branch outcome.
// Optional: MIPS_ALU_ISSUE_LUI_EN (lui handled in mips_alu_decode, result bypassed from the immediate).
module mips_alu_issue
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_rs_val,
    input  logic [WIDTH-1:0] in_rt_val,
    input  logic [15:0]      in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_is_branch,
    output logic             out_taken,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    s1_ctrl_t         dec_ctrl;
    logic [WIDTH-1:0] dec_a;
    logic [WIDTH-1:0] dec_b;

    logic             s1_valid;
    s1_ctrl_t         s1_ctrl;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [15:0]      s1_imm;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_adv;
    logic             accept;

    mips_alu_decode #(.WIDTH(WIDTH)) u_decode (
        .opcode (in_opcode),
        .funct  (in_funct),
        .rs_val (in_rs_val),
        .rt_val (in_rt_val),
        .imm    (in_imm),
        .ctrl   (dec_ctrl),
        .a      (dec_a),
        .b      (dec_b)
    );

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;

    assign alu_op = s1_ctrl.op;
    assign alu_a  = s1_a;
    assign alu_b  = s1_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ctrl  <= '{op: ALU_ADD, default: '0};
            s1_a     <= '0;
            s1_b     <= '0;
            s1_imm   <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_ctrl  <= dec_ctrl;
            s1_a     <= dec_a;
            s1_b     <= dec_b;
            s1_imm   <= in_imm;
            s1_tag   <= in_tag;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Bypassed entries (lui) take their value from the immediate instead of the ALU.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_zero      <= 1'b0;
            out_is_branch <= 1'b0;
            out_taken     <= 1'b0;
            out_illegal   <= 1'b0;
            out_tag       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s1_adv) begin
            out_valid     <= 1'b1;
            out_result    <= s1_ctrl.bypass ? WIDTH'({s1_imm, 16'b0}) : alu_result;
            out_zero      <= s1_ctrl.bypass ? (s1_imm == 16'd0) : alu_zero;
            out_is_branch <= s1_ctrl.is_branch;
            out_taken     <= s1_ctrl.is_branch && (s1_ctrl.is_bne ? !alu_zero : alu_zero);
            out_illegal   <= s1_ctrl.illegal;
            out_tag       <= s1_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_alu_issue.sv
// Directed-vector bench for mips_alu_issue with a behavioural ALU; honours MIPS_ALU_ISSUE_LUI_EN.
module tb_mips_alu_issue;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int NV    = 18;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_opcode;
    logic [5:0]       in_funct;
    logic [WIDTH-1:0] in_rs_val;
    logic [WIDTH-1:0] in_rt_val;
    logic [15:0]      in_imm;
    logic [TAG_W-1:0] in_tag;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_is_branch;
    logic             out_taken;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    int nVectors     = 0;
    int nMiscompares = 0;

    typedef struct {
        string       name;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [2:0]  eop;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] eres;
        logic        ez;
        logic        ebr;
        logic        etk;
        logic        eill;
    } vec_t;

    vec_t vecs[NV];

    mips_alu_issue #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_funct      (in_funct),
        .in_rs_val     (in_rs_val),
        .in_rt_val     (in_rt_val),
        .in_imm        (in_imm),
        .in_tag        (in_tag),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_is_branch (out_is_branch),
        .out_taken     (out_taken),
        .out_illegal   (out_illegal),
        .out_tag       (out_tag)
    );

    always #5 clk = ~clk;

    // Reference ALU standing in for the shared instance.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a & alu_b;
            3'b001:  alu_result = alu_a | alu_b;
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic driveInstr(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [15:0] imm, input logic [TAG_W-1:0] tag);
        in_opcode = opc;
        in_funct  = fn;
        in_rs_val = rs;
        in_rt_val = rt;
        in_imm    = imm;
        in_tag    = tag;
        in_valid  = 1'b1;
    endtask

    task automatic checkResetState(input string pfx);
        nVectors++;
        checkOutput({pfx, ".in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({pfx, ".out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({pfx, ".out_result"}, out_result, 32'd0);
        checkOutput({pfx, ".out_zero"}, 32'(out_zero), 32'd0);
        checkOutput({pfx, ".out_is_branch"}, 32'(out_is_branch), 32'd0);
        checkOutput({pfx, ".out_taken"}, 32'(out_taken), 32'd0);
        checkOutput({pfx, ".out_illegal"}, 32'(out_illegal), 32'd0);
        checkOutput({pfx, ".out_tag"}, 32'(out_tag), 32'd0);
        checkOutput({pfx, ".alu_op"}, 32'(alu_op), 32'd2);
        checkOutput({pfx, ".alu_a"}, alu_a, 32'd0);
        checkOutput({pfx, ".alu_b"}, alu_b, 32'd0);
    endtask

    // One isolated instruction: ALU drive checked after accept, output one cycle later.
    task automatic applyStimulus(input vec_t v, input logic [TAG_W-1:0] tag);
        nVectors++;
        out_ready = 1'b1;
        checkOutput({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
        driveInstr(v.opc, v.fn, v.rs, v.rt, v.imm, tag);
        tick();
        in_valid = 1'b0;
        checkOutput({v.name, ".alu_op"}, 32'(alu_op), 32'(v.eop));
        checkOutput({v.name, ".alu_a"}, alu_a, v.ea);
        checkOutput({v.name, ".alu_b"}, alu_b, v.eb);
        tick();
        checkOutput({v.name, ".out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({v.name, ".out_result"}, out_result, v.eres);
        checkOutput({v.name, ".out_zero"}, 32'(out_zero), 32'(v.ez));
        checkOutput({v.name, ".out_is_branch"}, 32'(out_is_branch), 32'(v.ebr));
        checkOutput({v.name, ".out_taken"}, 32'(out_taken), 32'(v.etk));
        checkOutput({v.name, ".out_illegal"}, 32'(out_illegal), 32'(v.eill));
        checkOutput({v.name, ".out_tag"}, 32'(out_tag), 32'(tag));
        tick();
        checkOutput({v.name, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"addu",    6'h00, 6'h21, 32'h5,        32'h7,        16'h0,    3'b010, 32'h5,        32'h7,        32'hC,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"add_zero",6'h00, 6'h20, 32'h3,        32'hFFFFFFFD, 16'h0,    3'b010, 32'h3,        32'hFFFFFFFD, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"subu",    6'h00, 6'h23, 32'hA,        32'h3,        16'h0,    3'b110, 32'hA,        32'h3,        32'h7,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"and",     6'h00, 6'h24, 32'hF0F0,     32'hFF00,     16'h0,    3'b000, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{"or",      6'h00, 6'h25, 32'hF0,       32'h0F,       16'h0,    3'b001, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"slt",     6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1,        16'h0,    3'b111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"beq",     6'h04, 6'h00, 32'h1234,     32'h1234,     16'h0,    3'b110, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{"bne_eq",  6'h05, 6'h00, 32'h1234,     32'h1234,     16'h0,    3'b110, 32'h1234,     32'h1234,     32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{"bne_ne",  6'h05, 6'h00, 32'h5,        32'h6,        16'h0,    3'b110, 32'h5,        32'h6,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{"slti",    6'h0A, 6'h00, 32'hFFFFFFFF, 32'h0,        16'h0001, 3'b111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"ori",     6'h0D, 6'h00, 32'h0,        32'h0,        16'h8000, 3'b001, 32'h0,        32'h8000,     32'h8000,     1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{"addiu",   6'h09, 6'h00, 32'hA,        32'h0,        16'hFFFF, 3'b010, 32'hA,        32'hFFFFFFFF, 32'h9,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"andi",    6'h0C, 6'h00, 32'hFFFFFFFF, 32'h0,        16'h8000, 3'b000, 32'hFFFFFFFF, 32'h8000,     32'h8000,     1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{"lw",      6'h23, 6'h00, 32'h1000,     32'h0,        16'hFFFC, 3'b010, 32'h1000,     32'hFFFFFFFC, 32'hFFC,      1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{"sw",      6'h2B, 6'h00, 32'h8,        32'h0,        16'h0004, 3'b010, 32'h8,        32'h4,        32'hC,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{"bad_op",  6'h3F, 6'h00, 32'h5,        32'h7,        16'h0,    3'b010, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{"bad_fn",  6'h00, 6'h00, 32'h5,        32'h7,        16'h0,    3'b010, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
`ifdef MIPS_ALU_ISSUE_LUI_EN
        vecs[17] = '{"lui",     6'h0F, 6'h00, 32'h5,        32'h0,        16'h1234, 3'b001, 32'h0,        32'h0,        32'h12340000, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        vecs[17] = '{"lui",     6'h0F, 6'h00, 32'h5,        32'h0,        16'h1234, 3'b010, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
`endif

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_opcode = '0;
        in_funct  = '0;
        in_rs_val = '0;
        in_rt_val = '0;
        in_imm    = '0;
        in_tag    = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        checkResetState("reset");

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i], TAG_W'(i + 1));
        end

        // Four back-to-back adds against a consumer stalled for three cycles.
        nVectors++;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    int waited;
                    waited = 0;
                    driveInstr(6'h00, 6'h21, 32'(i * 100), 32'(i), 16'h0, TAG_W'(i));
                    @(negedge clk);
                    if (i == 3) checkOutput("b2b.in_ready_drop", 32'(in_ready), 32'd0);
                    while (!in_ready && waited < 30) begin
                        @(negedge clk);
                        waited++;
                    end
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                checkOutput("b2b.hold_valid", 32'(out_valid), 32'd1);
                checkOutput("b2b.hold_tag", 32'(out_tag), 32'd1);
                out_ready = 1'b1;
            end
            begin
                int got;
                int cyc;
                got = 0;
                cyc = 0;
                while (got < 4 && cyc < 40) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid && out_ready) begin
                        got++;
                        checkOutput("b2b.tag", 32'(out_tag), 32'(got));
                        checkOutput("b2b.result", out_result, 32'(got * 101));
                    end
                end
                checkOutput("b2b.count", 32'(got), 32'd4);
            end
        join
        tick();
        tick();
        checkOutput("b2b.no_dup", 32'(out_valid), 32'd0);

        // Flush with both stages occupied, racing a new input.
        nVectors++;
        out_ready = 1'b0;
        driveInstr(6'h00, 6'h21, 32'h1, 32'h2, 16'h0, 5'd7);
        tick();
        driveInstr(6'h00, 6'h21, 32'h3, 32'h4, 16'h0, 5'd8);
        tick();
        checkOutput("flush.prefill", 32'(out_valid), 32'd1);
        driveInstr(6'h00, 6'h21, 32'h5, 32'h6, 16'h0, 5'd9);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush.out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            repeat (4) begin
                tick();
                if (out_valid) seen = 1'b1;
            end
            checkOutput("flush.nothing_emitted", 32'(seen), 32'd0);
        end

        // Reset pulse while S2 holds an unconsumed result.
        nVectors++;
        out_ready = 1'b0;
        driveInstr(6'h00, 6'h21, 32'h5, 32'h7, 16'h0, 5'd3);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("midrst.prefill_valid", 32'(out_valid), 32'd1);
        checkOutput("midrst.prefill_result", out_result, 32'hC);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkResetState("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
